mmio_uart: RTL and testbench

MMIO_UART -- requirements
Module: mmio_uart

---
 rtl/mmio_uart.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mmio_uart.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart.sv
// rtl/mmio_uart.sv - MMIO UART: TX FIFO + serializer; RX path built when MMIO_UART_RX_EN is defined
module mmio_uart #(
  parameter logic [15:0] BAUDDIV_RST = 16'd868,
  parameter int          TX_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mmio_i_addr,
  input  logic [3:0]  mmio_i_wmask,
  input  logic [31:0] mmio_i_wdata,
  output logic [31:0] mmio_o_rdata,
  output logic        uart_o_tx,
  input  logic        uart_i_rx
);

  localparam int AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(TX_DEPTH);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  logic       reg_sel, wr_en, wr_tx, wr_rx, wr_div;
  logic [1:0] reg_idx;

  assign reg_sel = (mmio_i_addr[11:4] == 8'd0);
  assign reg_idx = mmio_i_addr[3:2];
  assign wr_en   = reg_sel && mmio_i_wmask[0];
  assign wr_tx   = wr_en && (reg_idx == 2'd0);
  assign wr_rx   = wr_en && (reg_idx == 2'd2);
  assign wr_div  = wr_en && (reg_idx == 2'd3);

  logic [15:0] div, eff_div;
  assign eff_div = (div < 16'd2) ? 16'd2 : div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= BAUDDIV_RST;
    end else if (wr_div) begin
      div[7:0] <= mmio_i_wdata[7:0];
      if (mmio_i_wmask[1]) div[15:8] <= mmio_i_wdata[15:8];
    end
  end

  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_empty, fifo_full, tx_push, tx_pop;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
  // A push into a full FIFO still lands when the serializer pops in the same cycle
  assign tx_push    = wr_tx && (!fifo_full || tx_pop);

  always_ff @(posedge clk) begin
    if (tx_push) fifo_mem[wr_ptr] <= mmio_i_wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (tx_push) wr_ptr <= wr_ptr + AW'(1);
      if (tx_pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_cnt <= fifo_cnt + CW'(tx_push) - CW'(tx_pop);
    end
  end

  logic [1:0]  tx_state;
  logic [15:0] tx_cnt, tx_div;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_bit_end, tx_idle;

  assign tx_bit_end = (tx_cnt == tx_div - 16'd1);
  assign tx_pop     = !fifo_empty && ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_bit_end));
  assign tx_idle    = fifo_empty && (tx_state == TX_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= 16'd2;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_state <= TX_START;
            tx_cnt   <= '0;
            tx_div   <= eff_div;
            tx_shift <= fifo_mem[rd_ptr];
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_state <= TX_DATA;
            tx_cnt   <= '0;
            tx_bit   <= '0;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_cnt   <= '0;
            tx_shift <= tx_shift >> 1;
            tx_bit   <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) tx_state <= TX_STOP;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            // Chain straight into the next frame so queued bytes leave no idle gap
            if (tx_pop) begin
              tx_state <= TX_START;
              tx_div   <= eff_div;
              tx_shift <= fifo_mem[rd_ptr];
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    uart_o_tx = 1'b1;
    case (tx_state)
      TX_START: uart_o_tx = 1'b0;
      TX_DATA:  uart_o_tx = tx_shift[0];
      default:  uart_o_tx = 1'b1;
    endcase
  end

  logic       rx_valid, rx_overrun, rx_frame_err;
  logic [7:0] rx_byte;

`ifdef MMIO_UART_RX_EN
  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;

  logic [1:0]  rx_sync;
  logic        rx_s, rx_prev;
  logic [2:0]  rx_state, rx_bit;
  logic [15:0] rx_cnt, rx_div;
  logic [7:0]  rx_shift;
  logic        unused_rx;

  assign rx_s      = rx_sync[1];
  assign unused_rx = ^{mmio_i_wdata[31:16]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync      <= 2'b11;
      rx_prev      <= 1'b1;
      rx_state     <= RX_IDLE;
      rx_bit       <= '0;
      rx_cnt       <= '0;
      rx_div       <= 16'd2;
      rx_shift     <= '0;
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], uart_i_rx};
      rx_prev <= rx_s;
      if (wr_rx) begin
        rx_valid     <= 1'b0;
        rx_overrun   <= 1'b0;
        rx_frame_err <= 1'b0;
      end
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
            rx_div   <= eff_div;
          end
        end
        RX_START: begin
          if (rx_cnt == (rx_div >> 1) - 16'd1) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == rx_div - 16'd1) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == rx_div - 16'd1) begin
            rx_cnt <= '0;
            // Completion overrides a coincident clear: byte stays valid, overrun drops
            if (rx_s) begin
              rx_byte    <= rx_shift;
              rx_valid   <= 1'b1;
              rx_overrun <= wr_rx ? 1'b0 : (rx_overrun | rx_valid);
              rx_state   <= RX_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              rx_state     <= RX_WAIT;
            end
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        default: begin
          if (rx_s) rx_state <= RX_IDLE;
        end
      endcase
    end
  end
`else
  logic unused_rx;
  assign unused_rx    = ^{uart_i_rx, wr_rx, mmio_i_wdata[31:16]};
  assign rx_valid     = 1'b0;
  assign rx_overrun   = 1'b0;
  assign rx_frame_err = 1'b0;
  assign rx_byte      = 8'd0;
`endif

  logic unused_addr;
  assign unused_addr = ^{mmio_i_addr[31:12], mmio_i_addr[1:0]};

  always_comb begin
    mmio_o_rdata = 32'd0;
    if (reg_sel) begin
      case (reg_idx)
        2'd1:    mmio_o_rdata = {27'd0, rx_frame_err, rx_overrun, rx_valid, tx_idle, fifo_full};
        2'd2:    mmio_o_rdata = {24'd0, rx_byte};
        2'd3:    mmio_o_rdata = {16'd0, div};
        default: mmio_o_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart.sv
// tb/tb_mmio_uart.sv - self-checking bench for mmio_uart (RX tests when MMIO_UART_RX_EN is defined)
module tb_mmio_uart;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wmask;
  logic        tx, rx;

  int checks = 0;
  int errors = 0;

  bit cap_en = 1'b0;
  bit cap_q[$];
  bit exp_q[$];

  logic [7:0] exp_byte = 8'd0;
  bit exp_valid = 1'b0, exp_ovr = 1'b0, exp_ferr = 1'b0;

  always #5 clk = ~clk;

  mmio_uart dut (
    .clk          (clk),
    .rst          (rst),
    .mmio_i_addr  (addr),
    .mmio_i_wmask (wmask),
    .mmio_i_wdata (wdata),
    .mmio_o_rdata (rdata),
    .uart_o_tx    (tx),
    .uart_i_rx    (rx)
  );

  always @(negedge clk) if (cap_en) cap_q.push_back(tx);

  task automatic mmio_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    @(negedge clk);
    addr = a; wmask = m; wdata = d;
    @(posedge clk);
    #1 wmask = 4'h0;
  endtask

  task automatic mmio_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; wmask = 4'h0;
    #1 d = rdata;
  endtask

  // Ideal line waveform for one frame: start, 8 data bits LSB first, stop, each eff cycles
  function automatic void add_frame(input logic [7:0] b, input int d);
    int e = (d < 2) ? 2 : d;
    for (int k = 0; k < e; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < e; k++) exp_q.push_back(b[i]);
    for (int k = 0; k < e; k++) exp_q.push_back(1'b1);
  endfunction

  task automatic check_wave(input string name, input int extra);
    int guard = 0;
    int bad = -1;
    for (int i = 0; i < extra; i++) exp_q.push_back(1'b1);
    while (cap_q.size() < exp_q.size() && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    cap_en = 1'b0;
    checks++;
    if (cap_q.size() < exp_q.size()) begin
      errors++;
      $display("FAIL %s: captured %0d cycles, required %0d", name, cap_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++)
        if (bad < 0 && cap_q[i] !== exp_q[i]) bad = i;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s: cycle %0d uart_o_tx=%0b required %0b", name, bad, cap_q[bad], exp_q[bad]);
      end
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] expv);
    logic [31:0] d;
    mmio_read(a, d);
    checks++;
    if (d !== expv) begin
      errors++;
      $display("FAIL %s: read 0x%08h, required 0x%08h", name, d, expv);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop, input int d);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (d) @(negedge clk);
    end
    rx = 1'b1;
    repeat (2 * d) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; addr = 32'd0; wmask = 4'h0; wdata = 32'd0; rx = 1'b1;
    #3;
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx: uart_o_tx=%0b required 1", tx);
    end
    check_reg("reset_status", 32'h4, 32'h2);
    check_reg("reset_bauddiv", 32'hC, 32'd868);
    check_reg("reset_rxdata", 32'h8, 32'h0);
    #1 rst = 1'b0;
  endtask

  task automatic test_tx_frame;
    logic [7:0] b, b2;
    int d;
    mmio_write(32'hC, 4'h3, 32'd4);
    check_reg("bauddiv_set4", 32'hC, 32'd4);
    exp_q.delete(); cap_q.delete();
    exp_q.push_back(1'b1);
    add_frame(8'hA5, 4);
    mmio_write(32'h0, 4'h1, 32'hA5);
    cap_en = 1'b1;
    check_wave("tx_a5", 2);
    check_reg("tx_a5_idle", 32'h4, 32'h2);
    for (int n = 0; n < 4; n++) begin
      d = $urandom_range(0, 7);
      b = 8'($urandom);
      mmio_write(32'hC, 4'h3, d);
      exp_q.delete(); cap_q.delete();
      exp_q.push_back(1'b1);
      add_frame(b, d);
      mmio_write(32'h0, 4'h1, {24'd0, b});
      cap_en = 1'b1;
      check_wave($sformatf("tx_rand_div%0d", d), 3);
    end
    b = 8'($urandom); b2 = 8'($urandom);
    mmio_write(32'hC, 4'h3, 32'd3);
    exp_q.delete(); cap_q.delete();
    exp_q.push_back(1'b1);
    add_frame(b, 3);
    add_frame(b2, 6);
    mmio_write(32'h0, 4'h1, {24'd0, b});
    cap_en = 1'b1;
    mmio_write(32'h0, 4'h1, {24'd0, b2});
    repeat (5) @(posedge clk);
    mmio_write(32'hC, 4'h3, 32'd6);
    check_wave("tx_div_change_midframe", 4);
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [6];
    for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
    mmio_write(32'hC, 4'h3, 32'd4);
    exp_q.delete(); cap_q.delete();
    exp_q.push_back(1'b1);
    for (int i = 0; i < 5; i++) add_frame(bytes[i], 4);
    mmio_write(32'h0, 4'h1, {24'd0, bytes[0]});
    cap_en = 1'b1;
    for (int i = 1; i < 6; i++) mmio_write(32'h0, 4'h1, {24'd0, bytes[i]});
    check_reg("b2b_full", 32'h4, 32'h1);
    repeat (20) @(posedge clk);
    check_reg("b2b_still_full", 32'h4, 32'h1);
    repeat (20) @(posedge clk);
    check_reg("b2b_after_pop", 32'h4, 32'h0);
    check_wave("b2b_wave", 10);
    check_reg("b2b_idle", 32'h4, 32'h2);
  endtask

  task automatic test_decode;
    mmio_write(32'hC, 4'h3, 32'd4);
    mmio_write(32'h10, 4'hF, 32'hFFFF_FFFF);
    check_reg("offset10_read", 32'h10, 32'h0);
    check_reg("offset10_bauddiv", 32'hC, 32'd4);
    check_reg("offset10_status", 32'h4, 32'h2);
    check_reg("txdata_read", 32'h0, 32'h0);
    mmio_write(32'hC, 4'h2, 32'h0000_1234);
    check_reg("bauddiv_mask_no_b0", 32'hC, 32'd4);
    mmio_write(32'hC, 4'h1, 32'h0000_1234);
    check_reg("bauddiv_low_byte", 32'hC, 32'h34);
    mmio_write(32'hC, 4'h3, 32'hABCD_1234);
    check_reg("bauddiv_both_bytes", 32'hC, 32'h1234);
    check_reg("alias_40c", 32'h40C, 32'h0);
    mmio_write(32'h400, 4'h1, 32'h55);
    check_reg("alias_400_no_push", 32'h4, 32'h2);
  endtask

  task automatic test_reset_mid_frame;
    bit stayed_high = 1'b1;
    mmio_write(32'hC, 4'h3, 32'd4);
    mmio_write(32'h0, 4'h1, 32'h00);
    mmio_write(32'h0, 4'h1, 32'h00);
    repeat (15) @(posedge clk);
    #2;
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL midframe_line_low: uart_o_tx=%0b required 0", tx);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL midframe_reset_tx: uart_o_tx=%0b required 1", tx);
    end
    check_reg("midframe_reset_status", 32'h4, 32'h2);
    check_reg("midframe_reset_bauddiv", 32'hC, 32'd868);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) stayed_high = 1'b0;
    end
    checks++;
    if (!stayed_high) begin
      errors++;
      $display("FAIL midframe_after_reset_idle: uart_o_tx went low, required idle high");
    end
  endtask

`ifdef MMIO_UART_RX_EN
  function automatic void rx_model(input logic [7:0] b, input bit stop);
    if (stop) begin
      exp_ovr   = exp_ovr | exp_valid;
      exp_valid = 1'b1;
      exp_byte  = b;
    end else begin
      exp_ferr = 1'b1;
    end
  endfunction

  task automatic check_rx(input string name);
    check_reg({name, "_status"}, 32'h4, {27'd0, exp_ferr, exp_ovr, exp_valid, 1'b1, 1'b0});
    check_reg({name, "_rxdata"}, 32'h8, {24'd0, exp_byte});
  endtask

  task automatic rx_clear;
    mmio_write(32'h8, 4'h1, 32'h0);
    exp_valid = 1'b0; exp_ovr = 1'b0; exp_ferr = 1'b0;
  endtask

  task automatic test_rx;
    logic [7:0] b;
    int d;
    bit stop;
    exp_byte = 8'd0; exp_valid = 1'b0; exp_ovr = 1'b0; exp_ferr = 1'b0;
    mmio_write(32'hC, 4'h3, 32'd8);
    send_rx(8'h3C, 1'b1, 8); rx_model(8'h3C, 1'b1);
    check_rx("rx_3c");
    send_rx(8'h81, 1'b1, 8); rx_model(8'h81, 1'b1);
    check_rx("rx_overrun");
    rx_clear();
    check_rx("rx_clear");
    b = 8'($urandom);
    send_rx(b, 1'b1, 8); rx_model(b, 1'b1);
    b = 8'($urandom);
    send_rx(b, 1'b0, 8); rx_model(b, 1'b0);
    check_rx("rx_frame_err");
    @(negedge clk) rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check_rx("rx_glitch");
    for (int n = 0; n < 4; n++) begin
      d = $urandom_range(4, 10);
      b = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      mmio_write(32'hC, 4'h3, d);
      if ($urandom_range(0, 1) == 1) rx_clear();
      send_rx(b, stop, d); rx_model(b, stop);
      check_rx($sformatf("rx_rand%0d", n));
    end
  endtask
`else
  task automatic test_rx;
    mmio_write(32'hC, 4'h3, 32'd8);
    send_rx(8'h3C, 1'b1, 8);
    check_reg("norx_status", 32'h4, 32'h2);
    check_reg("norx_rxdata", 32'h8, 32'h0);
    send_rx(8'h5A, 1'b0, 8);
    mmio_write(32'h8, 4'h1, 32'hFF);
    check_reg("norx_status2", 32'h4, 32'h2);
  endtask
`endif

  initial begin
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_decode();
    test_rx();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
